// File: rtl/oisc8_pkg.sv
// Shared oisc8 types and bus address constants for the multi-cycle multiply/divide unit.
package oisc8_pkg;

    // Operation select latched with the operands.
    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } muldiv_op_t;

    // Control states of the iterative unit.
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } muldiv_state_t;

    // Bus port addresses; kept clear of the NXOR/NXORI slots.
    localparam int unsigned BUS_ADDR_W = 5;
    localparam logic [BUS_ADDR_W-1:0] MUL  = 5'h18;
    localparam logic [BUS_ADDR_W-1:0] MULI = 5'h19;
    localparam logic [BUS_ADDR_W-1:0] DIV  = 5'h1A;
    localparam logic [BUS_ADDR_W-1:0] DIVI = 5'h1B;

endpackage

// File: rtl/oisc_muldiv_unit_if.sv
// Request/result bundle between the bus port adapters and oisc_muldiv_unit.
// With OISC_MULDIV_SIGNED_EN defined an extra sgn request bit is carried.
interface oisc_muldiv_unit_if
    import oisc8_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) ();

    logic              start;
    muldiv_op_t        op;
    logic [WIDTH-1:0]  a_in;
    logic [WIDTH-1:0]  b_in;
`ifdef OISC_MULDIV_SIGNED_EN
    logic              sgn;
`endif
    logic              busy;
    logic              valid;
    logic [WIDTH-1:0]  res_lo;
    logic [WIDTH-1:0]  res_hi;
    logic              dbz;

    modport master (
`ifdef OISC_MULDIV_SIGNED_EN
        output sgn,
`endif
        output start, op, a_in, b_in,
        input  busy, valid, res_lo, res_hi, dbz
    );

    modport slave (
`ifdef OISC_MULDIV_SIGNED_EN
        input  sgn,
`endif
        input  start, op, a_in, b_in,
        output busy, valid, res_lo, res_hi, dbz
    );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration of the shift-add multiplier or restoring divider.
// MUL: {hi,lo} holds {partial, multiplier}; DIV: {hi,lo} holds {remainder, quotient}.
module muldiv_step
    import oisc8_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] hi_nxt_c,
    output logic [WIDTH-1:0] lo_nxt_c
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] sub;

    // Add/shift for MUL, shift/trial-subtract for DIV, all WIDTH+1 bits wide.
    always_comb begin
        hi_nxt_c = '0;
        lo_nxt_c = '0;
        sum      = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
        rem_sh   = {hi, lo[WIDTH-1]};
        sub      = rem_sh - {1'b0, operand};
        if (op == MD_MUL) begin
            hi_nxt_c = sum[WIDTH:1];
            lo_nxt_c = {sum[0], lo[WIDTH-1:1]};
        end else if (rem_sh >= {1'b0, operand}) begin
            hi_nxt_c = WIDTH'(sub);
            lo_nxt_c = {lo[WIDTH-2:0], 1'b1};
        end else begin
            hi_nxt_c = WIDTH'(rem_sh);
            lo_nxt_c = {lo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/oisc_muldiv_unit.sv
// Multi-cycle multiply/divide unit for the oisc8 datapath: WIDTH iterations per
// operation, divide-by-zero resolved in one cycle. busy stalls pc_block.
// Optional macro OISC_MULDIV_SIGNED_EN adds signed operation via magnitude/fix-up.
module oisc_muldiv_unit
    import oisc8_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    oisc_muldiv_unit_if.slave  bus
);

    muldiv_state_t     state_q;
    muldiv_op_t        op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [WIDTH-1:0]  hi_q;
    logic [WIDTH-1:0]  lo_q;
    logic [WIDTH-1:0]  opnd_q;
    logic [WIDTH-1:0]  res_lo_q;
    logic [WIDTH-1:0]  res_hi_q;
    logic              busy_q;
    logic              valid_q;
    logic              dbz_q;

    logic [WIDTH-1:0]  hi_nxt_c;
    logic [WIDTH-1:0]  lo_nxt_c;
    logic [WIDTH-1:0]  fin_lo_c;
    logic [WIDTH-1:0]  fin_hi_c;
    logic [WIDTH-1:0]  a_mag_c;
    logic [WIDTH-1:0]  b_mag_c;

`ifdef OISC_MULDIV_SIGNED_EN
    logic              neg_main_q;
    logic              neg_rem_q;
    logic              neg_main_c;
    logic              neg_rem_c;
    logic              a_neg_c;
    logic              b_neg_c;
    logic [2*WIDTH-1:0] prod_c;

    // Signed requests feed magnitudes to the core and remember the result signs.
    always_comb begin
        a_neg_c    = bus.sgn & bus.a_in[WIDTH-1];
        b_neg_c    = bus.sgn & bus.b_in[WIDTH-1];
        a_mag_c    = a_neg_c ? WIDTH'(-bus.a_in) : bus.a_in;
        b_mag_c    = b_neg_c ? WIDTH'(-bus.b_in) : bus.b_in;
        neg_main_c = a_neg_c ^ b_neg_c;
        neg_rem_c  = a_neg_c;
    end

    // Restore signs on the final iteration: product/quotient by XOR, remainder follows dividend.
    always_comb begin
        prod_c   = {hi_nxt_c, lo_nxt_c};
        fin_lo_c = lo_nxt_c;
        fin_hi_c = hi_nxt_c;
        if (op_q == MD_MUL) begin
            if (neg_main_q) begin
                prod_c = -prod_c;
            end
            fin_lo_c = prod_c[WIDTH-1:0];
            fin_hi_c = prod_c[2*WIDTH-1:WIDTH];
        end else begin
            if (neg_main_q) begin
                fin_lo_c = WIDTH'(-lo_nxt_c);
            end
            if (neg_rem_q) begin
                fin_hi_c = WIDTH'(-hi_nxt_c);
            end
        end
    end
`else
    // Unsigned only: operands and results pass straight through.
    always_comb begin
        a_mag_c  = bus.a_in;
        b_mag_c  = bus.b_in;
        fin_lo_c = lo_nxt_c;
        fin_hi_c = hi_nxt_c;
    end
`endif

    muldiv_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .op       (op_q),
        .hi       (hi_q),
        .lo       (lo_q),
        .operand  (opnd_q),
        .hi_nxt_c (hi_nxt_c),
        .lo_nxt_c (lo_nxt_c)
    );

    // Control FSM, iteration registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            op_q     <= MD_MUL;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            dbz_q    <= 1'b0;
`ifdef OISC_MULDIV_SIGNED_EN
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                MD_IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.op;
                        dbz_q  <= 1'b0;
                        hi_q   <= '0;
                        lo_q   <= (bus.op == MD_MUL) ? b_mag_c : a_mag_c;
                        opnd_q <= (bus.op == MD_MUL) ? a_mag_c : b_mag_c;
`ifdef OISC_MULDIV_SIGNED_EN
                        neg_main_q <= neg_main_c;
                        neg_rem_q  <= neg_rem_c;
`endif
                        if (bus.op == MD_DIV && bus.b_in == '0) begin
                            res_lo_q <= '1;
                            res_hi_q <= bus.a_in;
                            dbz_q    <= 1'b1;
                            valid_q  <= 1'b1;
                            state_q  <= MD_DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            cnt_q   <= CNT_W'(WIDTH);
                            state_q <= MD_RUN;
                        end
                    end
                end
                MD_RUN: begin
                    hi_q  <= hi_nxt_c;
                    lo_q  <= lo_nxt_c;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        res_lo_q <= fin_lo_c;
                        res_hi_q <= fin_hi_c;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    state_q <= MD_IDLE;
                end
                default: begin
                    state_q <= MD_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.valid  = valid_q;
    assign bus.res_lo = res_lo_q;
    assign bus.res_hi = res_hi_q;
    assign bus.dbz    = dbz_q;

endmodule
